// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity codes and the
// data-bit clamp helper.
package uart_tx_fifo_pkg;

    localparam int unsigned NBITS_W       = 4;
    localparam int unsigned MIN_DATA_BITS = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Force the requested frame size into MIN_DATA_BITS..max_bits.
    function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] n,
                                                       input int unsigned max_bits);
        logic [NBITS_W-1:0] r;
        r = n;
        if (n < NBITS_W'(MIN_DATA_BITS)) begin
            r = NBITS_W'(MIN_DATA_BITS);
        end else if (n > NBITS_W'(max_bits)) begin
            r = NBITS_W'(max_bits);
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty; head word is read combinationally.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push & ~full_q;
        do_pop  = pop & ~empty_q;
        wr_d    = wr_q + PTR_W'(do_push);
        rd_d    = rd_q + PTR_W'(do_pop);
        level_d = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        full_d  = (level_d == LVL_W'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO; frame format and baud divisor are latched at
// the start of each frame so mid-frame config changes only affect later frames.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned DIV_W         = 16
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic [3:0]                    cfg_nbits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic                          tx_enable,
    input  logic                          in_valid,
    input  logic [MAX_DATA_BITS-1:0]      in_data,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_done
);
    localparam int unsigned W     = MAX_DATA_BITS;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             fifo_full, fifo_empty, push_c, pop_c;
    logic [W-1:0]     fifo_head;
    logic [LVL_W-1:0] fifo_lvl;

    uart_sync_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_c),
        .push_data (in_data),
        .pop       (pop_c),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_lvl)
    );

    tx_state_e          state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d;
    logic [NBITS_W-1:0] bit_idx_q, bit_idx_d, nbits_q, nbits_d;
    logic [W-1:0]       shift_q, shift_d;
    logic               par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic               stop2_q, stop2_d, stop_idx_q, stop_idx_d;
    logic               txd_q, txd_d, busy_q, busy_d, done_q, done_d;

    logic [NBITS_W-1:0] nbits_c;
    logic [W-1:0]       masked_c;
    logic [LVL_W-1:0]   level_nxt;
    logic               bit_end, can_start;

    // Head word trimmed to the configured frame width, ready for launch.
    always_comb begin
        nbits_c = clamp_nbits(cfg_nbits, MAX_DATA_BITS);
        for (int i = 0; i < int'(W); i++) begin
            masked_c[i] = fifo_head[i] & (i < int'(nbits_c));
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        div_d      = div_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        txd_d      = txd_q;
        pop_c      = 1'b0;
        push_c     = in_valid & ~fifo_full;
        bit_end    = (cnt_q == div_q);
        can_start  = ~fifo_empty & tx_enable;

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                cnt_d = '0;
                pop_c = can_start;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == nbits_q - NBITS_W'(1)) begin
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d    = ST_STOP;
                            txd_d      = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + NBITS_W'(1);
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    cnt_d      = '0;
                    txd_d      = 1'b1;
                    stop_idx_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        txd_d   = 1'b1;
                        pop_c   = can_start;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Launch a new frame: pop the head and snapshot the runtime config.
        if (pop_c) begin
            state_d    = ST_START;
            cnt_d      = '0;
            txd_d      = 1'b0;
            div_d      = cfg_div;
            nbits_d    = nbits_c;
            shift_d    = masked_c;
            par_en_d   = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_d  = (^masked_c) ^ (cfg_parity == PAR_ODD);
            stop2_d    = cfg_stop2;
            stop_idx_d = 1'b0;
        end

        level_nxt = fifo_lvl + LVL_W'(push_c) - LVL_W'(pop_c);
        busy_d    = (state_d != ST_IDLE) || (level_nxt != '0);
        done_d    = (state_d == ST_STOP) && (cnt_d == div_d) && (stop_idx_d == stop2_d);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            div_q      <= '0;
            nbits_q    <= NBITS_W'(MIN_DATA_BITS);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready   = ~fifo_full;
    assign fifo_level = fifo_lvl;
    assign uart_txd   = txd_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected line waveforms are built from the frame rules
// (bit list repeated div+1 times) and compared cycle by cycle.
module tb_uart_tx_fifo;
    localparam int unsigned MAXB  = 9;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DIVW  = 16;

    logic            clk = 1'b0;
    logic            resetn;
    logic [DIVW-1:0] cfg_div;
    logic [3:0]      cfg_nbits;
    logic [1:0]      cfg_parity;
    logic            cfg_stop2;
    logic            tx_enable;
    logic            in_valid;
    logic [MAXB-1:0] in_data;
    logic            in_ready;
    logic [3:0]      fifo_level;
    logic            uart_txd;
    logic            tx_busy;
    logic            tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    bit exp_txd[$];
    bit exp_done[$];
    int model_cnt;

    logic [3:0] cur_nb;
    logic [1:0] cur_par;
    bit         cur_s2;
    int         cur_div;

    always #5 clk = ~clk;

    uart_tx_fifo #(.MAX_DATA_BITS(MAXB), .FIFO_DEPTH(DEPTH), .DIV_W(DIVW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_div    (cfg_div),
        .cfg_nbits  (cfg_nbits),
        .cfg_parity (cfg_parity),
        .cfg_stop2  (cfg_stop2),
        .tx_enable  (tx_enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fifo_level (fifo_level),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Append one frame's line waveform and tx_done pattern to the expectation queues.
    function automatic void add_frame(input logic [8:0] d, input logic [3:0] nb_raw,
                                      input logic [1:0] par, input bit s2, input int div);
        int nb;
        int ones;
        bit bits[$];
        nb   = (nb_raw < 5) ? 5 : ((int'(nb_raw) > int'(MAXB)) ? int'(MAXB) : int'(nb_raw));
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par == 2'b01) bits.push_back(bit'(ones % 2));
        if (par == 2'b10) bits.push_back(bit'(1 - (ones % 2)));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c <= div; c++) begin
                exp_txd.push_back(bits[b]);
                exp_done.push_back((b == bits.size() - 1) && (c == div));
            end
        end
    endfunction

    task automatic set_cfg(input int div, input logic [3:0] nb, input logic [1:0] par, input bit s2);
        cur_div    = div;
        cur_nb     = nb;
        cur_par    = par;
        cur_s2     = s2;
        cfg_div    = DIVW'(div);
        cfg_nbits  = nb;
        cfg_parity = par;
        cfg_stop2  = s2;
    endtask

    // Single push with the transmitter enabled; returns on the sample after the push edge.
    task automatic push_one(input string tag, input logic [8:0] d);
        add_frame(d, cur_nb, cur_par, cur_s2, cur_div);
        @(negedge clk);
        tx_enable = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_prelaunch_txd"}, uart_txd, 1);
        check({tag, "_prelaunch_lvl"}, fifo_level, 1);
        check({tag, "_prelaunch_busy"}, tx_busy, 1);
    endtask

    // Consume the expected waveform; optionally change cfg and push one word at act_cycle.
    task automatic stream(input string tag, input int act_cycle, input int ndiv,
                          input logic [3:0] nnb, input logic [1:0] npar, input bit ns2,
                          input logic [8:0] ndata);
        int bad;
        int n;
        bit et, ed;
        bad = 0;
        n   = 0;
        while (exp_txd.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            et = exp_txd.pop_front();
            ed = exp_done.pop_front();
            if (uart_txd !== et || tx_done !== ed || tx_busy !== 1'b1) bad++;
            if (n == act_cycle) begin
                set_cfg(ndiv, nnb, npar, ns2);
                add_frame(ndata, nnb, npar, ns2, ndiv);
                in_valid = 1'b1;
                in_data  = ndata;
            end
            n++;
        end
        check({tag, "_wave_bad_cycles"}, bad, 0);
        @(negedge clk);
        check({tag, "_idle_txd"}, uart_txd, 1);
        check({tag, "_idle_busy"}, tx_busy, 0);
        check({tag, "_idle_lvl"}, fifo_level, 0);
    endtask

    // Fill the FIFO with tx_enable low, then release and check back-to-back frames.
    task automatic burst(input string tag, input int k);
        logic [8:0] d;
        @(negedge clk);
        tx_enable = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < k; i++) begin
            d        = 9'($urandom);
            in_valid = 1'b1;
            in_data  = d;
            if (model_cnt < int'(DEPTH)) begin
                add_frame(d, cur_nb, cur_par, cur_s2, cur_div);
                model_cnt++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_level"}, fifo_level, model_cnt);
        check({tag, "_in_ready"}, in_ready, (model_cnt < int'(DEPTH)) ? 1 : 0);
        check({tag, "_busy_held"}, tx_busy, 1);
        check({tag, "_line_idle"}, uart_txd, 1);
        tx_enable = 1'b1;
        stream(tag, -1, 0, 4'd0, 2'd0, 1'b0, 9'd0);
    endtask

    initial begin
        int bad;
        resetn    = 1'b0;
        tx_enable = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        set_cfg(3, 4'd8, 2'b00, 1'b0);
        @(negedge clk);
        check("rst_txd", uart_txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // 8N1, div=3, 0xA5
        set_cfg(3, 4'd8, 2'b00, 1'b0);
        push_one("t1", 9'h0A5);
        stream("t1", -1, 0, 4'd0, 2'd0, 1'b0, 9'd0);

        // 7 bits, even / odd parity, two stop bits
        set_cfg(1, 4'd7, 2'b01, 1'b1);
        push_one("t2e", 9'h003);
        stream("t2e", -1, 0, 4'd0, 2'd0, 1'b0, 9'd0);
        set_cfg(1, 4'd7, 2'b10, 1'b1);
        push_one("t2o", 9'h003);
        stream("t2o", -1, 0, 4'd0, 2'd0, 1'b0, 9'd0);

        // Overfill with transmitter disabled, then drain back-to-back
        set_cfg(1, 4'd8, 2'b00, 1'b0);
        burst("t3", 9);

        // div=0, 5N1
        set_cfg(0, 4'd5, 2'b00, 1'b0);
        push_one("t4", 9'h01F);
        stream("t4", -1, 0, 4'd0, 2'd0, 1'b0, 9'd0);

        // Mid-frame cfg change with a second word queued
        set_cfg(3, 4'd8, 2'b00, 1'b0);
        push_one("t6", 9'h05A);
        stream("t6", 10, 1, 4'd5, 2'b01, 1'b0, 9'h013);

        // Randomized frames and bursts, including out-of-range nbits
        for (int it = 0; it < 12; it++) begin
            set_cfg(int'($urandom_range(0, 4)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if (it % 2 == 0) begin
                push_one("rnd_single", 9'($urandom));
                stream("rnd_single", -1, 0, 4'd0, 2'd0, 1'b0, 9'd0);
            end else begin
                burst("rnd_burst", int'($urandom_range(1, 4)));
            end
        end

        // Asynchronous reset in the middle of a data bit
        set_cfg(7, 4'd8, 2'b00, 1'b0);
        @(negedge clk);
        tx_enable = 1'b1;
        in_valid  = 1'b1;
        in_data   = 9'h000;
        @(negedge clk);
        in_data = 9'h0FF;
        @(negedge clk);
        in_data = 9'h055;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_pre_txd", uart_txd, 0);
        check("t5_pre_lvl", fifo_level, 2);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_rst_txd", uart_txd, 1);
        check("t5_rst_lvl", fifo_level, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_busy", tx_busy, 0);
        @(negedge clk);
        resetn = 1'b1;
        exp_txd.delete();
        exp_done.delete();
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || fifo_level !== 4'd0) bad++;
        end
        check("t5_post_idle_bad_cycles", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
